// File: rtl/matrix_calc_pkg.sv
// Shared command, error and ASCII definitions for the UART command front end.
package matrix_calc_pkg;

  typedef enum logic [2:0] {
    CMD_MATRIX  = 3'd0,
    CMD_GEN     = 3'd1,
    CMD_CONFIG  = 3'd2,
    CMD_DISPLAY = 3'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_CHAR  = 3'd1,
    ERR_DIM   = 3'd2,
    ERR_RANGE = 3'd3,
    ERR_COUNT = 3'd4
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEYWORD,
    ST_ARG,
    ST_SKIP
  } state_e;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_D     = 8'h44;
  localparam logic [7:0] ASCII_G     = 8'h47;
  localparam logic [7:0] ASCII_M     = 8'h4D;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/dec_token_acc.sv
// Decimal token accumulator: sign, magnitude (acc*10+digit) and sticky overflow.
// State updates one cycle after each strobe; clr_i wins over digit/minus.
module dec_token_acc #(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    digit_vld_i,
  input  logic [3:0]              digit_i,
  input  logic                    minus_i,
  output logic signed [DATA_W+3:0] val_o,
  output logic                    pending_o,
  output logic                    digit_seen_o,
  output logic                    ovf_o
);

  localparam int ACC_W = DATA_W + 4;

  logic [ACC_W-1:0] mag_q, mag_d;
  logic             neg_q, neg_d;
  logic             seen_q, seen_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W+3:0] prod;

  always_comb begin
    prod   = {4'd0, mag_q} * (ACC_W+4)'(10) + {{ACC_W{1'b0}}, digit_i};
    mag_d  = mag_q;
    neg_d  = neg_q;
    seen_d = seen_q;
    ovf_d  = ovf_q;
    if (clr_i) begin
      mag_d  = '0;
      neg_d  = 1'b0;
      seen_d = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      if (minus_i) neg_d = 1'b1;
      if (digit_vld_i) begin
        seen_d = 1'b1;
        // Magnitude is kept below 2^(ACC_W-1) so negation can never wrap.
        if (ovf_q || (prod[ACC_W+3:ACC_W-1] != '0)) ovf_d = 1'b1;
        else mag_d = prod[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q  <= '0;
      neg_q  <= 1'b0;
      seen_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      mag_q  <= mag_d;
      neg_q  <= neg_d;
      seen_q <= seen_d;
      ovf_q  <= ovf_d;
    end
  end

  assign val_o        = neg_q ? -$signed(mag_q) : $signed(mag_q);
  assign pending_o    = neg_q | seen_q;
  assign digit_seen_o = seen_q;
  assign ovf_o        = ovf_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses ASCII command lines (MATRIX/GEN/CONFIG/DISPLAY) from a byte stream into fields.
// All outputs registered, one cycle after the consuming byte; no backpressure, one byte per cycle.
module uart_cmd_decoder
  import matrix_calc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DIM_W   = 3,
  parameter int MAX_DIM = 5,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [2:0]               cmd_type,
  output logic [DIM_W-1:0]         dim_m,
  output logic [DIM_W-1:0]         dim_n,
  output logic [CNT_W-1:0]         gen_count,
  output logic signed [DATA_W-1:0] elem_data,
  output logic [2*DIM_W-1:0]       elem_idx,
  output logic                     elem_valid,
  output logic signed [DATA_W-1:0] cfg_min,
  output logic signed [DATA_W-1:0] cfg_max,
  output logic                     cmd_done,
  output logic                     cmd_err,
  output logic [2:0]               err_code,
  output logic                     busy
);

  localparam int ACC_W = DATA_W + 4;
  localparam int IDX_W = 2 * DIM_W;
  localparam int TOK_W = IDX_W + 1;

  localparam logic signed [ACC_W-1:0] VAL_MAX  = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] VAL_MIN  = ACC_W'(-(2**(DATA_W-1)));
  localparam logic signed [ACC_W-1:0] DIM_MAXV = ACC_W'(MAX_DIM);
  localparam logic signed [ACC_W-1:0] CNT_MAXV = ACC_W'(2**CNT_W - 1);
  localparam logic signed [ACC_W-1:0] ZERO_V   = '0;

  state_e                   state_q, state_d;
  cmd_e                     cmd_q, cmd_d;
  err_e                     err_code_q, err_code_d;
  logic [DIM_W-1:0]         dim_m_q, dim_m_d, dim_n_q, dim_n_d;
  logic [CNT_W-1:0]         gen_cnt_q, gen_cnt_d;
  logic signed [DATA_W-1:0] elem_data_q, elem_data_d;
  logic [IDX_W-1:0]         elem_idx_q, elem_idx_d;
  logic                     elem_vld_q, elem_vld_d;
  logic signed [DATA_W-1:0] cfg_min_q, cfg_min_d, cfg_max_q, cfg_max_d;
  logic signed [DATA_W-1:0] sh_min_q, sh_min_d, sh_max_q, sh_max_d;
  logic                     done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [TOK_W-1:0]         tok_cnt_q, tok_cnt_d;

  logic                     acc_clr, acc_dig, acc_minus;
  logic signed [ACC_W-1:0]  acc_val;
  logic                     acc_pending, acc_seen, acc_ovf;
  logic                     is_term, is_space, is_dig, is_minus, is_kw;
  logic                     val_ok, dim_ok, cnt_ok;
  logic                     tok_end, fail;
  err_e                     fail_code;
  logic [IDX_W-1:0]         area_q, area_d;
  logic [TOK_W-1:0]         tok_need;

  dec_token_acc #(.DATA_W(DATA_W)) u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (acc_clr),
    .digit_vld_i  (acc_dig),
    .digit_i      (rx_data[3:0]),
    .minus_i      (acc_minus),
    .val_o        (acc_val),
    .pending_o    (acc_pending),
    .digit_seen_o (acc_seen),
    .ovf_o        (acc_ovf)
  );

  assign is_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
  assign is_space = (rx_data == ASCII_SPACE);
  assign is_dig   = is_digit(rx_data);
  assign is_minus = (rx_data == ASCII_MINUS);
  assign is_kw    = (rx_data == ASCII_M) || (rx_data == ASCII_G) ||
                    (rx_data == ASCII_C) || (rx_data == ASCII_D);

  assign val_ok = !acc_ovf && (acc_val >= VAL_MIN) && (acc_val <= VAL_MAX);
  assign dim_ok = !acc_ovf && (acc_val > ZERO_V) && (acc_val <= DIM_MAXV);
  assign cnt_ok = !acc_ovf && (acc_val >= ZERO_V) && (acc_val <= CNT_MAXV);
  assign area_q = {{DIM_W{1'b0}}, dim_m_q} * {{DIM_W{1'b0}}, dim_n_q};

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    err_code_d  = err_code_q;
    dim_m_d     = dim_m_q;
    dim_n_d     = dim_n_q;
    gen_cnt_d   = gen_cnt_q;
    elem_data_d = elem_data_q;
    elem_idx_d  = elem_idx_q;
    elem_vld_d  = 1'b0;
    cfg_min_d   = cfg_min_q;
    cfg_max_d   = cfg_max_q;
    sh_min_d    = sh_min_q;
    sh_max_d    = sh_max_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    busy_d      = busy_q;
    tok_cnt_d   = tok_cnt_q;
    acc_clr     = 1'b0;
    acc_dig     = 1'b0;
    acc_minus   = 1'b0;
    tok_end     = 1'b0;
    fail        = 1'b0;
    fail_code   = ERR_NONE;
    area_d      = '0;
    tok_need    = '0;

    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (is_kw) begin
            state_d   = ST_KEYWORD;
            busy_d    = 1'b1;
            tok_cnt_d = '0;
            acc_clr   = 1'b1;
            case (rx_data)
              ASCII_M: cmd_d = CMD_MATRIX;
              ASCII_G: cmd_d = CMD_GEN;
              ASCII_C: cmd_d = CMD_CONFIG;
              default: cmd_d = CMD_DISPLAY;
            endcase
          end
        end

        ST_KEYWORD: begin
          if (is_term) begin
            fail      = 1'b1;
            fail_code = ERR_COUNT;
            state_d   = ST_IDLE;
          end else if (is_space) begin
            state_d = ST_ARG;
          end
        end

        ST_ARG: begin
          if (is_dig) begin
            acc_dig = 1'b1;
          end else if (is_minus) begin
            if (acc_pending) begin
              fail      = 1'b1;
              fail_code = ERR_CHAR;
            end else begin
              acc_minus = 1'b1;
            end
          end else if (is_space || is_term) begin
            tok_end = acc_pending;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_CHAR;
          end

          if (tok_end) begin
            acc_clr = 1'b1;
            if (!acc_seen) begin
              fail      = 1'b1;
              fail_code = ERR_CHAR;
            end else if (cmd_q == CMD_CONFIG) begin
              if (tok_cnt_q == '0) begin
                if (!val_ok) begin
                  fail      = 1'b1;
                  fail_code = ERR_RANGE;
                end else sh_min_d = acc_val[DATA_W-1:0];
              end else if (tok_cnt_q == TOK_W'(1)) begin
                if (!val_ok || ($signed(acc_val[DATA_W-1:0]) < sh_min_q)) begin
                  fail      = 1'b1;
                  fail_code = ERR_RANGE;
                end else sh_max_d = acc_val[DATA_W-1:0];
              end else begin
                fail      = 1'b1;
                fail_code = ERR_COUNT;
              end
            end else if (tok_cnt_q < TOK_W'(2)) begin
              if (!dim_ok) begin
                fail      = 1'b1;
                fail_code = ERR_DIM;
              end else if (tok_cnt_q == '0) dim_m_d = acc_val[DIM_W-1:0];
              else dim_n_d = acc_val[DIM_W-1:0];
            end else if ((cmd_q == CMD_GEN) && (tok_cnt_q == TOK_W'(2))) begin
              if (!cnt_ok) begin
                fail      = 1'b1;
                fail_code = ERR_RANGE;
              end else gen_cnt_d = acc_val[CNT_W-1:0];
            end else if ((cmd_q == CMD_MATRIX) &&
                         (tok_cnt_q < ({1'b0, area_q} + TOK_W'(2)))) begin
              if (!val_ok) begin
                fail      = 1'b1;
                fail_code = ERR_RANGE;
              end else begin
                elem_vld_d  = 1'b1;
                elem_data_d = acc_val[DATA_W-1:0];
                elem_idx_d  = IDX_W'(tok_cnt_q - TOK_W'(2));
              end
            end else begin
              fail      = 1'b1;
              fail_code = ERR_COUNT;
            end
            if (!fail) tok_cnt_d = tok_cnt_q + TOK_W'(1);
          end

          if (is_term && !fail) begin
            // Dimensions may have been set by this very byte, so size off the _d values.
            area_d = {{DIM_W{1'b0}}, dim_m_d} * {{DIM_W{1'b0}}, dim_n_d};
            case (cmd_q)
              CMD_MATRIX: tok_need = {1'b0, area_d} + TOK_W'(2);
              CMD_GEN:    tok_need = TOK_W'(3);
              default:    tok_need = TOK_W'(2);
            endcase
            if ((tok_cnt_d >= TOK_W'(2)) && (tok_cnt_d == tok_need)) begin
              done_d = 1'b1;
              busy_d = 1'b0;
              if (cmd_q == CMD_CONFIG) begin
                cfg_min_d = sh_min_d;
                cfg_max_d = sh_max_d;
              end
            end else begin
              fail      = 1'b1;
              fail_code = ERR_COUNT;
            end
          end

          if (is_term) state_d = ST_IDLE;
          else if (fail) state_d = ST_SKIP;
        end

        ST_SKIP: begin
          if (is_term) state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase

      if (fail) begin
        err_d      = 1'b1;
        err_code_d = fail_code;
        busy_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_MATRIX;
      err_code_q  <= ERR_NONE;
      dim_m_q     <= '0;
      dim_n_q     <= '0;
      gen_cnt_q   <= '0;
      elem_data_q <= '0;
      elem_idx_q  <= '0;
      elem_vld_q  <= 1'b0;
      cfg_min_q   <= '0;
      cfg_max_q   <= DATA_W'(9);
      sh_min_q    <= '0;
      sh_max_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      tok_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      err_code_q  <= err_code_d;
      dim_m_q     <= dim_m_d;
      dim_n_q     <= dim_n_d;
      gen_cnt_q   <= gen_cnt_d;
      elem_data_q <= elem_data_d;
      elem_idx_q  <= elem_idx_d;
      elem_vld_q  <= elem_vld_d;
      cfg_min_q   <= cfg_min_d;
      cfg_max_q   <= cfg_max_d;
      sh_min_q    <= sh_min_d;
      sh_max_q    <= sh_max_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      tok_cnt_q   <= tok_cnt_d;
    end
  end

  assign cmd_type   = cmd_q;
  assign dim_m      = dim_m_q;
  assign dim_n      = dim_n_q;
  assign gen_count  = gen_cnt_q;
  assign elem_data  = elem_data_q;
  assign elem_idx   = elem_idx_q;
  assign elem_valid = elem_vld_q;
  assign cfg_min    = cfg_min_q;
  assign cfg_max    = cfg_max_q;
  assign cmd_done   = done_q;
  assign cmd_err    = err_q;
  assign err_code   = err_code_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: command strings in, observed pulses/fields compared to hand values.
module tb_uart_cmd_decoder;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic [2:0]        cmd_type;
  logic [2:0]        dim_m, dim_n;
  logic [3:0]        gen_count;
  logic signed [7:0] elem_data;
  logic [5:0]        elem_idx;
  logic              elem_valid;
  logic signed [7:0] cfg_min, cfg_max;
  logic              cmd_done, cmd_err;
  logic [2:0]        err_code;
  logic              busy;

  int tests_run = 0;
  int tests_failed = 0;

  uart_cmd_decoder dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_type(cmd_type), .dim_m(dim_m), .dim_n(dim_n), .gen_count(gen_count),
    .elem_data(elem_data), .elem_idx(elem_idx), .elem_valid(elem_valid),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge, away from the DUT's active edge.
  int                elem_n = 0, done_n = 0, err_n = 0;
  logic [5:0]        idx_log [64];
  logic signed [7:0] dat_log [64];
  logic              done_with_elem = 1'b0;
  logic [2:0]        last_err = 3'd0;
  logic signed [7:0] cfg_min_prev = 8'sd0, cfg_max_prev = 8'sd0;
  logic signed [7:0] cfg_min_before = 8'sd0, cfg_max_before = 8'sd0;

  always @(negedge clk) begin
    if (elem_valid) begin
      idx_log[elem_n[5:0]] = elem_idx;
      dat_log[elem_n[5:0]] = elem_data;
      elem_n++;
    end
    if (cmd_done) begin
      done_n++;
      done_with_elem = elem_valid;
      cfg_min_before = cfg_min_prev;
      cfg_max_before = cfg_max_prev;
    end
    if (cmd_err) begin
      err_n++;
      last_err = err_code;
    end
    cfg_min_prev = cfg_min;
    cfg_max_prev = cfg_max;
  end

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_data  = s[i];
      rx_valid = 1'b1;
      if (gaps) begin
        @(negedge clk);
        rx_data  = "M";
        rx_valid = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    idle(3);
    tests_run++; if (cmd_type !== 3'd0) begin tests_failed++; $display("FAIL reset_cmd_type got %0d want 0", cmd_type); end
    tests_run++; if (cfg_max !== 8'sd9) begin tests_failed++; $display("FAIL reset_cfg_max got %0d want 9", cfg_max); end
    tests_run++; if (cfg_min !== 8'sd0) begin tests_failed++; $display("FAIL reset_cfg_min got %0d want 0", cfg_min); end
    tests_run++; if ({elem_valid, cmd_done, cmd_err, busy} !== 4'b0) begin tests_failed++; $display("FAIL reset_strobes got %b want 0000", {elem_valid, cmd_done, cmd_err, busy}); end
    tests_run++; if ({dim_m, dim_n, gen_count, err_code} !== 13'd0) begin tests_failed++; $display("FAIL reset_fields got %h want 0", {dim_m, dim_n, gen_count, err_code}); end
    rst_n = 1'b1;
    idle(2);
    tests_run++; if (cfg_max !== 8'sd9) begin tests_failed++; $display("FAIL post_reset_cfg_max got %0d want 9", cfg_max); end
  endtask

  task automatic test_matrix;
    int e0 = elem_n;
    int d0 = done_n;
    int r0 = err_n;
    send_str("M", 1'b0);
    idle(1);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL matrix_busy got %b want 1", busy); end
    send_str(" 2 2 1 -3 10 4\n", 1'b0);
    idle(3);
    tests_run++; if (elem_n - e0 !== 4) begin tests_failed++; $display("FAIL matrix_elem_count got %0d want 4", elem_n - e0); end
    tests_run++; if (idx_log[e0[5:0]] !== 6'd0 || dat_log[e0[5:0]] !== 8'sd1) begin tests_failed++; $display("FAIL matrix_e0 got (%0d,%0d) want (0,1)", idx_log[e0[5:0]], dat_log[e0[5:0]]); end
    tests_run++; if (idx_log[6'(e0+1)] !== 6'd1 || dat_log[6'(e0+1)] !== -8'sd3) begin tests_failed++; $display("FAIL matrix_e1 got (%0d,%0d) want (1,-3)", idx_log[6'(e0+1)], dat_log[6'(e0+1)]); end
    tests_run++; if (idx_log[6'(e0+2)] !== 6'd2 || dat_log[6'(e0+2)] !== 8'sd10) begin tests_failed++; $display("FAIL matrix_e2 got (%0d,%0d) want (2,10)", idx_log[6'(e0+2)], dat_log[6'(e0+2)]); end
    tests_run++; if (idx_log[6'(e0+3)] !== 6'd3 || dat_log[6'(e0+3)] !== 8'sd4) begin tests_failed++; $display("FAIL matrix_e3 got (%0d,%0d) want (3,4)", idx_log[6'(e0+3)], dat_log[6'(e0+3)]); end
    tests_run++; if (done_n - d0 !== 1 || err_n - r0 !== 0) begin tests_failed++; $display("FAIL matrix_done got done=%0d err=%0d want 1 0", done_n - d0, err_n - r0); end
    tests_run++; if (done_with_elem !== 1'b1) begin tests_failed++; $display("FAIL matrix_done_with_last got %b want 1", done_with_elem); end
    tests_run++; if (dim_m !== 3'd2 || dim_n !== 3'd2 || cmd_type !== 3'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL matrix_fields got m=%0d n=%0d type=%0d busy=%b want 2 2 0 0", dim_m, dim_n, cmd_type, busy); end
  endtask

  task automatic test_config;
    int d0 = done_n;
    int r0 = err_n;
    send_str("C -5 20\015", 1'b0);
    idle(3);
    tests_run++; if (done_n - d0 !== 1) begin tests_failed++; $display("FAIL config_done got %0d want 1", done_n - d0); end
    tests_run++; if (cfg_min_before !== 8'sd0 || cfg_max_before !== 8'sd9) begin tests_failed++; $display("FAIL config_pre_done got (%0d,%0d) want (0,9)", cfg_min_before, cfg_max_before); end
    tests_run++; if (cfg_min !== -8'sd5 || cfg_max !== 8'sd20 || cmd_type !== 3'd2) begin tests_failed++; $display("FAIL config_bounds got (%0d,%0d,%0d) want (-5,20,2)", cfg_min, cfg_max, cmd_type); end
    send_str("C 7 3\015", 1'b0);
    idle(3);
    tests_run++; if (err_n - r0 !== 1 || last_err !== 3'd3) begin tests_failed++; $display("FAIL config_minmax_err got n=%0d code=%0d want 1 3", err_n - r0, last_err); end
    tests_run++; if (cfg_min !== -8'sd5 || cfg_max !== 8'sd20) begin tests_failed++; $display("FAIL config_unchanged got (%0d,%0d) want (-5,20)", cfg_min, cfg_max); end
  endtask

  task automatic test_dim_err;
    int e0 = elem_n;
    int d0 = done_n;
    int r0 = err_n;
    send_str("M 6 1 1\n", 1'b0);
    idle(3);
    tests_run++; if (err_n - r0 !== 1 || last_err !== 3'd2 || err_code !== 3'd2) begin tests_failed++; $display("FAIL dim_err got n=%0d code=%0d want 1 2", err_n - r0, last_err); end
    tests_run++; if (elem_n - e0 !== 0) begin tests_failed++; $display("FAIL dim_no_elem got %0d want 0", elem_n - e0); end
    send_str("D 1 1\n", 1'b0);
    idle(3);
    tests_run++; if (done_n - d0 !== 1 || dim_m !== 3'd1 || dim_n !== 3'd1 || cmd_type !== 3'd3) begin tests_failed++; $display("FAIL display got done=%0d m=%0d n=%0d type=%0d want 1 1 1 3", done_n - d0, dim_m, dim_n, cmd_type); end
  endtask

  task automatic test_count_err;
    int e0 = elem_n;
    int d0 = done_n;
    int r0 = err_n;
    send_str("M 1 2 5\n", 1'b0);
    idle(3);
    tests_run++; if (elem_n - e0 !== 1 || dat_log[e0[5:0]] !== 8'sd5 || idx_log[e0[5:0]] !== 6'd0) begin tests_failed++; $display("FAIL short_matrix_elem got n=%0d data=%0d want 1 5", elem_n - e0, dat_log[e0[5:0]]); end
    tests_run++; if (err_n - r0 !== 1 || last_err !== 3'd4 || done_n - d0 !== 0) begin tests_failed++; $display("FAIL short_matrix_err got n=%0d code=%0d done=%0d want 1 4 0", err_n - r0, last_err, done_n - d0); end
    send_str("G 2 2 3 9\n", 1'b0);
    idle(3);
    tests_run++; if (err_n - r0 !== 2 || last_err !== 3'd4) begin tests_failed++; $display("FAIL gen_extra_err got n=%0d code=%0d want 2 4", err_n - r0, last_err); end
  endtask

  task automatic test_range_char;
    int e0 = elem_n;
    int d0 = done_n;
    int r0 = err_n;
    send_str("M 1 1 200\n", 1'b0);
    idle(3);
    tests_run++; if (err_n - r0 !== 1 || last_err !== 3'd3 || elem_n - e0 !== 0) begin tests_failed++; $display("FAIL range_200 got n=%0d code=%0d elem=%0d want 1 3 0", err_n - r0, last_err, elem_n - e0); end
    send_str("M 1 1 x\n", 1'b0);
    idle(3);
    tests_run++; if (err_n - r0 !== 2 || last_err !== 3'd1) begin tests_failed++; $display("FAIL char_x got n=%0d code=%0d want 2 1", err_n - r0, last_err); end
    send_str("M 1 1 -128\n", 1'b0);
    idle(3);
    tests_run++; if (done_n - d0 !== 1 || elem_n - e0 !== 1 || dat_log[e0[5:0]] !== -8'sd128) begin tests_failed++; $display("FAIL range_min got done=%0d data=%0d want 1 -128", done_n - d0, dat_log[e0[5:0]]); end
    send_str("G 1 1 16\n", 1'b0);
    idle(3);
    tests_run++; if (err_n - r0 !== 3 || last_err !== 3'd3) begin tests_failed++; $display("FAIL gen_16 got n=%0d code=%0d want 3 3", err_n - r0, last_err); end
    send_str("G 1 1 15\n", 1'b0);
    idle(3);
    tests_run++; if (done_n - d0 !== 2 || gen_count !== 4'd15) begin tests_failed++; $display("FAIL gen_15 got done=%0d count=%0d want 2 15", done_n - d0, gen_count); end
    send_str("G 1 M\n", 1'b0);
    idle(3);
    tests_run++; if (err_n - r0 !== 4 || last_err !== 3'd1) begin tests_failed++; $display("FAIL kw_in_arg got n=%0d code=%0d want 4 1", err_n - r0, last_err); end
    send_str("D 2 3-\n", 1'b0);
    idle(3);
    tests_run++; if (err_n - r0 !== 5 || last_err !== 3'd1) begin tests_failed++; $display("FAIL late_minus got n=%0d code=%0d want 5 1", err_n - r0, last_err); end
  endtask

  task automatic test_mid_reset;
    int d0 = done_n;
    int r0 = err_n;
    send_str("C 1 2 M 2 2 1 ", 1'b0);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    tests_run++; if (cfg_max !== 8'sd9 || busy !== 1'b0 || cfg_min !== 8'sd0) begin tests_failed++; $display("FAIL midreset_state got max=%0d min=%0d busy=%b want 9 0 0", cfg_max, cfg_min, busy); end
    rst_n = 1'b1;
    idle(2);
    d0 = done_n;
    r0 = err_n;
    send_str("G 3 3 2\n", 1'b0);
    idle(3);
    tests_run++; if (done_n - d0 !== 1 || err_n - r0 !== 0 || gen_count !== 4'd2) begin tests_failed++; $display("FAIL midreset_gen got done=%0d err=%0d count=%0d want 1 0 2", done_n - d0, err_n - r0, gen_count); end
    tests_run++; if (dim_m !== 3'd3 || dim_n !== 3'd3 || cmd_type !== 3'd1) begin tests_failed++; $display("FAIL midreset_dims got m=%0d n=%0d type=%0d want 3 3 1", dim_m, dim_n, cmd_type); end
  endtask

  task automatic test_back_to_back;
    int e0 = elem_n;
    int d0 = done_n;
    int r0 = err_n;
    send_str("xyz9 DISP  2   3\n", 1'b1);
    idle(3);
    tests_run++; if (done_n - d0 !== 1 || err_n - r0 !== 0 || dim_m !== 3'd2 || dim_n !== 3'd3) begin tests_failed++; $display("FAIL gapped_display got done=%0d err=%0d m=%0d n=%0d want 1 0 2 3", done_n - d0, err_n - r0, dim_m, dim_n); end
    send_str("MATRIX 1 1 7\nM 1 1 -9\r", 1'b0);
    idle(3);
    tests_run++; if (done_n - d0 !== 3 || elem_n - e0 !== 2 || dat_log[e0[5:0]] !== 8'sd7 || dat_log[6'(e0+1)] !== -8'sd9) begin tests_failed++; $display("FAIL back_to_back got done=%0d elem=%0d d0=%0d d1=%0d want 3 2 7 -9", done_n - d0, elem_n - e0, dat_log[e0[5:0]], dat_log[6'(e0+1)]); end
    tests_run++; if (idx_log[6'(e0+1)] !== 6'd0) begin tests_failed++; $display("FAIL idx_restart got %0d want 0", idx_log[6'(e0+1)]); end
  endtask

  initial begin
    test_reset();
    test_matrix();
    test_config();
    test_dim_err();
    test_count_err();
    test_range_char();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
